imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage of the pipelined RISC-V core.
- Extracts and sign/zero-extends immediates to XLEN for all base formats, plus CSR zimm and shift-amount forms.
- Sits between fetch/decode and the ID/EX register, behind a valid/ready handshake.
- A 2-entry skid buffer absorbs execute-stage stalls without a combinational ready path.
- A flush input supports branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of sideband carried alongside the instruction (typically PC).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  drop all buffered entries and any same-cycle input.
in_valid  in  1  input entry valid.
in_ready  out  1  block can accept an entry.
in_instr  in  32  raw instruction word.
in_immsrc  in  3  immediate format select.
in_tag  in  TAG_W  sideband, passed through unchanged.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  extended immediate.
out_immsrc  out  3  format select of the output entry.
out_tag  out  TAG_W  sideband of the output entry.
err_illegal  out  1  sticky illegal-immediate flag.

Behaviour:
- immsrc encoding and result, with sx = sign-extend to XLEN:
  - 000 I: sx(instr[31:20]).
  - 001 S: sx({instr[31:25], instr[11:7]}).
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sx({instr[31:12], 12'b0}).
  - 101 Z: zero-extend instr[19:15].
  - 110 SHAMT: zero-extend instr[25:20] when XLEN=64; instr[24:20] when XLEN=32.
  - 111 NONE: result = last_imm.
- last_imm: register holding the immediate of the most recent accepted non-NONE entry. Reset value 0. Not altered by flush.
- Accept = in_valid && in_ready. Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N when the main slot is free.
- in_ready = !skid_valid && !reset. It is a registered term only, with no combinational path from out_ready.
- Main slot holds out_*; skid slot is a second entry.
  - Accept while the main slot is empty or draining (out_ready high) → entry loads into main.
  - Accept while out_valid && !out_ready → entry loads into skid.
  - Main drains and skid is valid → skid moves to main, and skid clears.
  - FIFO order is always preserved. At most 2 entries are held; a third is never accepted.
  - Simultaneous accept, drain and skid-valid cannot occur, because in_ready=0 whenever skid is valid.
- flush has priority over every other event. At the next edge both valid bits clear and the same-cycle input is discarded. out_imm/out_tag data need not clear.
- err_illegal sets on accept of SHAMT with XLEN=32 and instr[25]=1. That entry still passes with imm = instr[24:20]. Cleared only by reset.
- Reset (asynchronous):
  - out_valid=0, in_ready=0, err_illegal=0.
  - out_imm=0, out_immsrc=3'b111, out_tag=0, last_imm=0.
  - in_ready rises on the first edge after reset deasserts, via the !reset term.
- A reset asserted mid-operation discards all entries immediately.
- out_* are stable while out_valid && !out_ready.

Decomposition:
- Package imm_pkg:
  - localparams for the IMM_I/S/B/J/U/Z/SHAMT/NONE encodings.
  - XLEN legality check.
  - a function for the sign-extension helper.
- Sub-module imm_decode: purely combinational (instr, immsrc, last_imm) → (imm, illegal). Reused by the compressed-decode path later.
- imm_gen_pipe holds the skid/handshake logic and instantiates imm_decode once.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093, immsrc 000, out_ready=1 → next cycle out_imm=0xFFFFFFFF, out_valid=1.
- S, U and J back-to-back: 0xFE112E23/001, 0x000153B7/100, 0xFF9FF06F/011 → out_imm 0xFFFFFFFC, 0x00015000, 0xFFFFFFF8 on consecutive cycles, with tags matching.
- Backpressure: hold out_ready=0 and send tags 1, 2 → in_ready=0 after the second accept. Release out_ready → tag 1 then tag 2 out, in_ready=1 again.
- Flush with both slots full: assert flush while in_valid=1 with tag 3 → next cycle out_valid=0. Tag 3 never appears; a new entry after flush passes with 1-cycle latency.
- Illegal SHAMT (XLEN=32): instr 0x02009093, immsrc 110 → err_illegal=1 and stays 1, out_imm=0. A following NONE entry → out_imm=0x00000000 (last_imm). With XLEN=64 the same instr gives out_imm=32 and err_illegal=0.
- Async reset mid-stream with skid full → out_valid, in_ready and err_illegal drop without a clock edge. out_immsrc=3'b111 and out_imm=0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared encodings and helpers for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_Z     = 3'b101;
  localparam logic [2:0] IMM_SHAMT = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Every format is first built as a 32-bit value whose sign bit is correct,
  // so widening to RV64 is a plain sign extension.
  function automatic logic [63:0] sx32to64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all base formats plus zimm/shamt.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  input  logic [XLEN-1:0] last_imm_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [31:0]     raw32;
  logic [XLEN-1:0] ext;
  logic            unused_opcode;

  // The opcode field never contributes to an immediate.
  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    raw32     = '0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I: raw32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: raw32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: raw32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J: raw32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      IMM_U: raw32 = {instr_i[31:12], 12'b0};
      IMM_Z: raw32 = {27'b0, instr_i[19:15]};
      IMM_SHAMT: begin
        if (XLEN == 64) begin
          raw32 = {26'b0, instr_i[25:20]};
        end else begin
          // RV32 has no shamt[5]; flag it but still pass the low five bits.
          raw32     = {27'b0, instr_i[24:20]};
          illegal_o = instr_i[25];
        end
      end
      default: raw32 = '0;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_rv64
      assign ext = sx32to64(raw32);
    end else begin : g_rv32
      assign ext = raw32;
    end
  endgenerate

  assign imm_o = (immsrc_i == IMM_NONE) ? last_imm_i : ext;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer between decode and ID/EX.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_immsrc,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_illegal
);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_src_q,   main_src_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_src_q,   skid_src_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic [XLEN-1:0]  last_imm_q,   last_imm_d;
  logic             err_q,        err_d;
  logic             rdy_q;

  logic accept;
  logic main_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i    (in_instr),
    .immsrc_i   (in_immsrc),
    .last_imm_i (last_imm_q),
    .imm_o      (dec_imm),
    .illegal_o  (dec_illegal)
  );

  // Handshake: an entry transfers on a cycle where valid and ready are both
  // high. in_ready depends only on registered state and reset, never on
  // out_ready, so upstream sees no combinational path through this block.
  assign in_ready  = rdy_q && !skid_valid_q && !reset;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_src_d   = main_src_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_src_d   = skid_src_q;
    skid_tag_d   = skid_tag_q;
    last_imm_d   = last_imm_q;
    err_d        = err_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // Skid holds the older entry, so it always wins the main slot.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_src_d   = skid_src_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_src_d   = in_immsrc;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_src_d   = in_immsrc;
      skid_tag_d   = in_tag;
    end

    if (accept && (in_immsrc != IMM_NONE)) begin
      last_imm_d = dec_imm;
    end
    if (accept && dec_illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_src_q   <= IMM_NONE;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_src_q   <= IMM_NONE;
      skid_tag_q   <= '0;
      last_imm_q   <= '0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_src_q   <= main_src_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_src_q   <= skid_src_d;
      skid_tag_q   <= skid_tag_d;
      last_imm_q   <= last_imm_d;
      err_q        <= err_d;
      rdy_q        <= 1'b1;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_immsrc  = main_src_q;
  assign out_tag     = main_tag_q;
  assign err_illegal = err_q;

endmodule
